// File: rtl/serializer.sv
// Parallel-to-serial shifter for the UART TX datapath: loads a word on ser_en and emits it one bit per clock.
// Latency: first bit on ser_data from the accepting edge; DATA_WIDTH cycles per frame, ser_done on the last bit.
// Backpressure: none; ser_en is only honoured when idle or in the last-bit cycle, otherwise ignored.
module serializer #(
    parameter int DATA_WIDTH = 8,
    parameter bit LSB_FIRST  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  ser_en,
    output logic                  ser_done,
    output logic                  ser_data
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [CW-1:0]         cnt;

    logic [DATA_WIDTH-1:0] next_word;
    logic                  next_bit;
    logic                  first_bit;
    logic                  last_bit;
    logic                  accept;

    // The register always holds the word aligned so the bit on the wire sits at the outgoing end.
    always_comb begin
        next_word = LSB_FIRST ? (shift_reg >> 1) : (shift_reg << 1);
        next_bit  = LSB_FIRST ? next_word[0] : next_word[DATA_WIDTH-1];
        first_bit = LSB_FIRST ? P_DATA[0] : P_DATA[DATA_WIDTH-1];
        last_bit  = (state == SHIFT) && (cnt == LAST);
        accept    = ser_en && ((state == IDLE) || last_bit);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shift_reg <= '0;
            cnt       <= '0;
            ser_data  <= 1'b0;
            ser_done  <= 1'b0;
        end else if (accept) begin
            // Also covers the back-to-back case: new frame starts on the edge that ends the old one.
            state     <= SHIFT;
            shift_reg <= P_DATA;
            cnt       <= '0;
            ser_data  <= first_bit;
            ser_done  <= (LAST == '0);
        end else if (state == SHIFT && !last_bit) begin
            shift_reg <= next_word;
            cnt       <= cnt + 1'b1;
            ser_data  <= next_bit;
            ser_done  <= ((cnt + 1'b1) == LAST);
        end else begin
            state    <= IDLE;
            cnt      <= '0;
            ser_data <= 1'b0;
            ser_done <= 1'b0;
        end
    end

endmodule

// File: tb/tb_serializer.sv
// Bench for serializer: directed vector table, MSB-first sequence, then random traffic against a frame-timing model.
module tb_serializer;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          ser_en;
    logic [DW-1:0] p_data;
    logic          l_data, l_done;
    logic          m_data, m_done;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    serializer #(.DATA_WIDTH(DW), .LSB_FIRST(1'b1)) dut_l (
        .clk(clk), .rst(rst), .P_DATA(p_data), .ser_en(ser_en),
        .ser_done(l_done), .ser_data(l_data)
    );

    serializer #(.DATA_WIDTH(DW), .LSB_FIRST(1'b0)) dut_m (
        .clk(clk), .rst(rst), .P_DATA(p_data), .ser_en(ser_en),
        .ser_done(m_done), .ser_data(m_data)
    );

    typedef struct {
        logic          rst;
        logic          en;
        logic [DW-1:0] pd;
        logic          exp_data;
        logic          exp_done;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(logic r, logic e, logic [DW-1:0] p, logic d, logic dn);
        vec_t x;
        x.rst = r; x.en = e; x.pd = p; x.exp_data = d; x.exp_done = dn;
        return x;
    endfunction

    // Reference model: a frame is (word, start edge); output at edge n is bit (n - start) of that word.
    int            edge_n = 0;
    bit            f_act  = 0;
    int            f_e0   = 0;
    logic [DW-1:0] f_word = '0;

    task automatic model_edge(input logic r, input logic e, input logic [DW-1:0] p);
        bit finishing;
        edge_n++;
        finishing = f_act && ((edge_n - 1 - f_e0) >= DW - 1);
        if (r) begin
            f_act = 0;
        end else if (e && (!f_act || finishing)) begin
            f_act  = 1;
            f_e0   = edge_n;
            f_word = p;
        end else if (finishing) begin
            f_act = 0;
        end
    endtask

    task automatic check(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at edge %0d: got %b, expected %b", name, edge_n, act, exp);
        end
    endtask

    task automatic check_model();
        int   k;
        logic el, em, ed;
        el = 1'b0; em = 1'b0; ed = 1'b0;
        if (f_act) begin
            k  = edge_n - f_e0;
            el = f_word[k];
            em = f_word[DW-1-k];
            ed = (k == DW - 1);
        end
        check("model_lsb_data", l_data, el);
        check("model_lsb_done", l_done, ed);
        check("model_msb_data", m_data, em);
        check("model_msb_done", m_done, ed);
    endtask

    // Inputs are set before the edge; outputs are sampled 1 time unit after it.
    task automatic step(input logic r, input logic e, input logic [DW-1:0] p);
        rst = r; ser_en = e; p_data = p;
        @(posedge clk);
        model_edge(r, e, p);
        #1;
        check_model();
    endtask

    initial begin
        logic [DW-1:0] msb_word;
        logic [DW-1:0] msb_exp;
        rst = 1'b1; ser_en = 1'b0; p_data = '0;

        // Reset holding off a pending request
        tbl.push_back(v(1, 1, 8'hFF, 0, 0));
        tbl.push_back(v(1, 1, 8'hFF, 0, 0));
        // Single frame 0xAA, then P_DATA changes while idle-bound
        tbl.push_back(v(0, 1, 8'hAA, 0, 0));
        tbl.push_back(v(0, 0, 8'hF0, 1, 0));
        tbl.push_back(v(0, 0, 8'hF0, 0, 0));
        tbl.push_back(v(0, 0, 8'hF0, 1, 0));
        tbl.push_back(v(0, 0, 8'hF0, 0, 0));
        tbl.push_back(v(0, 0, 8'hF0, 1, 0));
        tbl.push_back(v(0, 0, 8'hF0, 0, 0));
        tbl.push_back(v(0, 0, 8'hF0, 1, 1));
        tbl.push_back(v(0, 0, 8'hF0, 0, 0));
        tbl.push_back(v(0, 0, 8'hF0, 0, 0));
        // Back-to-back 0x0F then 0x81 requested in the done cycle
        tbl.push_back(v(0, 1, 8'h0F, 1, 0));
        tbl.push_back(v(0, 0, 8'h00, 1, 0));
        tbl.push_back(v(0, 0, 8'h00, 1, 0));
        tbl.push_back(v(0, 0, 8'h00, 1, 0));
        tbl.push_back(v(0, 0, 8'h00, 0, 0));
        tbl.push_back(v(0, 0, 8'h00, 0, 0));
        tbl.push_back(v(0, 0, 8'h00, 0, 0));
        tbl.push_back(v(0, 0, 8'h00, 0, 1));
        tbl.push_back(v(0, 1, 8'h81, 1, 0));
        tbl.push_back(v(0, 0, 8'h00, 0, 0));
        tbl.push_back(v(0, 0, 8'h00, 0, 0));
        tbl.push_back(v(0, 0, 8'h00, 0, 0));
        tbl.push_back(v(0, 0, 8'h00, 0, 0));
        tbl.push_back(v(0, 0, 8'h00, 0, 0));
        tbl.push_back(v(0, 0, 8'h00, 0, 0));
        tbl.push_back(v(0, 0, 8'h00, 1, 1));
        tbl.push_back(v(0, 0, 8'h00, 0, 0));
        // 0x3C with a stray request at bit 3
        tbl.push_back(v(0, 1, 8'h3C, 0, 0));
        tbl.push_back(v(0, 0, 8'h00, 0, 0));
        tbl.push_back(v(0, 0, 8'h00, 1, 0));
        tbl.push_back(v(0, 1, 8'hFF, 1, 0));
        tbl.push_back(v(0, 0, 8'h00, 1, 0));
        tbl.push_back(v(0, 0, 8'h00, 1, 0));
        tbl.push_back(v(0, 0, 8'h00, 0, 0));
        tbl.push_back(v(0, 0, 8'h00, 0, 1));
        tbl.push_back(v(0, 0, 8'h00, 0, 0));
        tbl.push_back(v(0, 0, 8'h00, 0, 0));
        // 0xFF aborted by reset at bit 4, then a fresh frame
        tbl.push_back(v(0, 1, 8'hFF, 1, 0));
        tbl.push_back(v(0, 0, 8'h00, 1, 0));
        tbl.push_back(v(0, 0, 8'h00, 1, 0));
        tbl.push_back(v(0, 0, 8'h00, 1, 0));
        tbl.push_back(v(1, 0, 8'h00, 0, 0));
        tbl.push_back(v(0, 0, 8'h00, 0, 0));
        tbl.push_back(v(0, 0, 8'h00, 0, 0));
        tbl.push_back(v(0, 0, 8'h00, 0, 0));
        tbl.push_back(v(0, 1, 8'hFF, 1, 0));
        for (int i = 0; i < 6; i++) tbl.push_back(v(0, 0, 8'h00, 1, 0));
        tbl.push_back(v(0, 0, 8'h00, 1, 1));
        tbl.push_back(v(0, 0, 8'h00, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst, tbl[i].en, tbl[i].pd);
            check("tbl_data", l_data, tbl[i].exp_data);
            check("tbl_done", l_done, tbl[i].exp_done);
        end

        // MSB-first frame 0xC1: expected stream 1,1,0,0,0,0,0,1
        msb_exp = 8'b1000_0011;
        msb_word = 8'hC1;
        for (int i = 0; i < DW; i++) begin
            step(1'b0, (i == 0), (i == 0) ? msb_word : 8'h00);
            check("msb_data", m_data, msb_exp[i]);
            check("msb_done", m_done, (i == DW - 1));
        end
        step(1'b0, 1'b0, 8'h00);
        check("msb_idle", m_data, 1'b0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(99, 0) < 2), ($urandom_range(99, 0) < 30), DW'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/serializer.md
Name: serializer

Overview:
- Parallel-to-serial shifter for the UART transmitter datapath.
- Captures one parallel byte on a single-cycle enable pulse and shifts it out one bit per clock, LSB first, on ser_data.
- Flags the final bit with ser_done so the TX controller FSM can advance to the parity/stop stage.
- Sits between the TX FSM (which drives ser_en) and the TX output mux (which consumes ser_data).

Parameters:
- DATA_WIDTH, 8, number of bits in P_DATA and number of serial bit-cycles per frame.
- LSB_FIRST, 1, 1 = bit 0 is sent first (UART order); 0 = MSB sent first.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- P_DATA  input  DATA_WIDTH  parallel word; sampled only on the accepting edge.
- ser_en  input  1  load/start request, normally a one-cycle pulse from the TX FSM.
- ser_done  output  1  high during the cycle the last data bit is on ser_data.
- ser_data  output  1  serial bit stream, registered.

Behaviour:
- Reset (rst=1 at a rising edge), regardless of state:
  - State goes to IDLE; shift register and bit counter clear to 0.
  - ser_data=0, ser_done=0.
  - Reset mid-frame aborts the frame; no further bits and no ser_done for it.
- States: IDLE, SHIFT.
- IDLE with ser_en=1 at edge E0:
  - Latch P_DATA.
  - Drive ser_data with the first bit (P_DATA[0] when LSB_FIRST=1) from E0.
  - Set counter=0 and go to SHIFT.
- IDLE with ser_en=0: ser_data=0, ser_done=0; P_DATA ignored.
- SHIFT:
  - At each edge, counter increments and ser_data takes the next bit.
  - Bit k is valid on ser_data from edge E0+k to E0+k+1, for k=0..DATA_WIDTH-1.
  - ser_done is registered. It is high exactly from E0+DATA_WIDTH-1 to E0+DATA_WIDTH (the last-bit cycle) and low otherwise.
- End of frame, at edge E0+DATA_WIDTH:
  - ser_en=1: accept a new word (back-to-back frame; no idle gap; first new bit appears at this edge).
  - Otherwise: return to IDLE; ser_data=0, ser_done=0.
- ser_en asserted during SHIFT, except in the last-bit cycle, is ignored; the frame in progress is not restarted or corrupted.
- P_DATA changes after the accepting edge have no effect on the frame in progress.
- Latency: 0 cycles from the accepting edge to the first bit; DATA_WIDTH cycles per frame.
- Counter width: ceil(log2(DATA_WIDTH)) bits, no wrap beyond DATA_WIDTH-1.
- No combinational path from inputs to outputs.

Test Plan:
1. Reset: hold rst=1 for 2 cycles with ser_en=1 and P_DATA=0xFF -> ser_data=0 and ser_done=0 throughout; no frame starts.
2. Single frame: P_DATA=0xAA, ser_en=1 for one cycle, then ser_en=0 and P_DATA=0xF0 -> ser_data over 8 cycles = 0,1,0,1,0,1,0,1; ser_done high only on the 8th bit; then ser_data=0 and idle (0xF0 never sent).
3. Back-to-back: send 0x0F, then assert ser_en with P_DATA=0x81 in the ser_done cycle -> stream 1,1,1,1,0,0,0,0,1,0,0,0,0,0,0,1 with no gap; ser_done pulses at bit 8 and bit 16.
4. ser_en during shift: start 0x3C, pulse ser_en with P_DATA=0xFF at bit 3 -> stream stays 0,0,1,1,1,1,0,0; ser_done fires once.
5. Reset mid-frame: start 0xFF, assert rst at bit 4 -> ser_data=0 from the reset edge; no ser_done; a new ser_en after reset sends a full fresh frame.
6. MSB-first variant (LSB_FIRST=0): P_DATA=0xC1 -> stream 1,1,0,0,0,0,0,1, ser_done on the last bit.
